// File: rtl/rom_load_arbiter.sv
// Arbitrates the single-port ROM RAM between the HPS download stream (via a 2-entry write FIFO)
// and the core read port, sequencing LOAD/FLUSH/HOLD and holding the core in reset until the image is complete.
module rom_load_arbiter #(
   parameter int ROM_BYTES   = 65536,
   parameter int HOLD_CYCLES = 255
) (
   input  logic        clk_sys,
   input  logic        RESET_N,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic        ext_reset,
   input  logic        rd_req,
   input  logic [15:0] rd_addr,
   output logic        rd_ack,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_din,
   output logic        mem_we,
   output logic        core_reset,
   output logic [16:0] dl_bytes,
   output logic        dl_err
);

   localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES);
   localparam logic [25:0]   ROM_LIMIT = 26'(ROM_BYTES);

   typedef enum logic [1:0] {RUN, LOAD, FLUSH, HOLD} state_t;

   state_t         state, state_nxt;
   logic [HW-1:0]  hold_cnt, hold_nxt;
   logic           dl_prev;
   logic           dl_rise;
   logic           clear;

   logic [23:0]    fifo_q [2];
   logic [1:0]     fifo_cnt, cnt_nxt;
   logic [23:0]    entry;
   logic           in_range;
   logic           push_req, push, pop, overflow, oor;

   logic           wr_grant;
   logic           rd_grant;
   logic           rd_pend;

   assign dl_rise  = ioctl_download & ~dl_prev;
   assign in_range = {1'b0, ioctl_addr} < ROM_LIMIT;
   assign entry    = {ioctl_addr[15:0], ioctl_dout};

   assign push_req = ioctl_wr && (state == LOAD) && in_range;
   assign oor      = ioctl_wr && (state == LOAD) && !in_range;
   assign overflow = push_req && (fifo_cnt == 2'd2);
   assign push     = push_req && (fifo_cnt != 2'd2);

   // The write port always wins; a read waits one idle cycle after each grant so acks never overlap.
   assign wr_grant = (fifo_cnt != 2'd0) && ((state == LOAD) || (state == FLUSH));
   assign pop      = wr_grant;
   assign rd_grant = rd_req && !rd_pend && !wr_grant;

   always_comb begin
      cnt_nxt = fifo_cnt;
      if (push && !pop) begin
         cnt_nxt = fifo_cnt + 2'd1;
      end else if (pop && !push) begin
         cnt_nxt = fifo_cnt - 2'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      clear     = 1'b0;
      case (state)
         RUN: begin
            if (dl_rise) begin
               state_nxt = LOAD;
               clear     = 1'b1;
            end
         end
         LOAD: begin
            if (!ioctl_download) state_nxt = FLUSH;
         end
         FLUSH: begin
            // Leave as the last entry drains so the hold window starts from the empty edge.
            if (dl_rise) begin
               state_nxt = LOAD;
            end else if (cnt_nxt == 2'd0) begin
               state_nxt = HOLD;
               hold_nxt  = HOLD_INIT;
            end
         end
         HOLD: begin
            if (dl_rise) begin
               state_nxt = LOAD;
               clear     = 1'b1;
            end else if (hold_cnt == '0) begin
               state_nxt = RUN;
            end else begin
               hold_nxt = hold_cnt - 1'b1;
            end
         end
         default: state_nxt = HOLD;
      endcase
   end

   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= HOLD;
         hold_cnt   <= HOLD_INIT;
         dl_prev    <= 1'b0;
         core_reset <= 1'b1;
      end else begin
         state      <= state_nxt;
         hold_cnt   <= hold_nxt;
         dl_prev    <= ioctl_download;
         core_reset <= (state_nxt != RUN) | ext_reset;
      end
   end

   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         fifo_cnt  <= 2'd0;
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
      end else if (clear) begin
         fifo_cnt <= 2'd0;
      end else begin
         fifo_cnt <= cnt_nxt;
         if (push && pop) begin
            fifo_q[0] <= entry;
         end else if (push) begin
            fifo_q[fifo_cnt[0]] <= entry;
         end else if (pop) begin
            fifo_q[0] <= fifo_q[1];
         end
      end
   end

   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
         rd_pend  <= 1'b0;
         rd_ack   <= 1'b0;
      end else begin
         mem_we  <= 1'b0;
         rd_pend <= rd_grant;
         rd_ack  <= rd_pend;
         if (wr_grant) begin
            mem_we   <= 1'b1;
            mem_addr <= fifo_q[0][23:8];
            mem_din  <= fifo_q[0][7:0];
         end else if (rd_grant) begin
            mem_addr <= rd_addr;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         dl_bytes <= '0;
         dl_err   <= 1'b0;
      end else if (clear) begin
         dl_bytes <= '0;
         dl_err   <= 1'b0;
      end else begin
         if (wr_grant && !(&dl_bytes)) dl_bytes <= dl_bytes + 17'd1;
         if (oor || overflow) dl_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rom_load_arbiter.sv
// Directed bench for rom_load_arbiter: table-driven download writes plus hand-written
// sequences for hold timing, reads, FIFO overflow, flush draining and mid-load reset.
module tb_rom_load_arbiter;

   logic        clk_sys = 1'b0;
   logic        RESET_N;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ext_reset;
   logic        rd_req;
   logic [15:0] rd_addr;
   logic        rd_ack;
   logic [15:0] mem_addr;
   logic [7:0]  mem_din;
   logic        mem_we;
   logic        core_reset;
   logic [16:0] dl_bytes;
   logic        dl_err;

   int tests = 0;
   int fails = 0;

   always #5 clk_sys = ~clk_sys;

   rom_load_arbiter #(.ROM_BYTES(65536), .HOLD_CYCLES(255)) dut (
      .clk_sys        (clk_sys),
      .RESET_N        (RESET_N),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ext_reset      (ext_reset),
      .rd_req         (rd_req),
      .rd_addr        (rd_addr),
      .rd_ack         (rd_ack),
      .mem_addr       (mem_addr),
      .mem_din        (mem_din),
      .mem_we         (mem_we),
      .core_reset     (core_reset),
      .dl_bytes       (dl_bytes),
      .dl_err         (dl_err)
   );

   typedef struct {
      logic [24:0] addr;
      logic [7:0]  dout;
      logic        exp_we;
      logic [16:0] exp_bytes;
      logic        exp_err;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      @(negedge clk_sys);
   endtask

   // Counts sampled cycles with core_reset high, starting from the current sample.
   task automatic count_reset_high(output int hi, output int we_seen);
      hi = 0;
      we_seen = 0;
      while (core_reset === 1'b1 && hi < 400) begin
         hi++;
         if (mem_we === 1'b1) we_seen++;
         tick();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi;
      int we_seen;
      int n;

      vecs[0] = '{25'h0000000, 8'hAA, 1'b1, 17'd1, 1'b0};
      vecs[1] = '{25'h0000001, 8'hAA, 1'b1, 17'd2, 1'b0};
      vecs[2] = '{25'h0000002, 8'hAA, 1'b1, 17'd3, 1'b0};
      vecs[3] = '{25'h0000003, 8'hAA, 1'b1, 17'd4, 1'b0};
      vecs[4] = '{25'h0010000, 8'h77, 1'b0, 17'd4, 1'b1};
      vecs[5] = '{25'h000FFFF, 8'h5A, 1'b1, 17'd5, 1'b1};

      RESET_N = 1'b0;
      ioctl_download = 1'b0;
      ioctl_wr = 1'b0;
      ioctl_addr = '0;
      ioctl_dout = '0;
      ext_reset = 1'b0;
      rd_req = 1'b0;
      rd_addr = '0;
      repeat (3) @(negedge clk_sys);

      chk("rst_core_reset", core_reset, 1);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_din", mem_din, 0);
      chk("rst_rd_ack", rd_ack, 0);
      chk("rst_dl_bytes", dl_bytes, 0);
      chk("rst_dl_err", dl_err, 0);

      // Power-up hold: HOLD_CYCLES+1 cycles of core_reset.
      RESET_N = 1'b1;
      count_reset_high(hi, we_seen);
      chk("powerup_hold_len", hi, 256);

      rd_addr = 16'h0010;
      rd_req = 1'b1;
      tick();
      chk("rd_mem_addr", mem_addr, 16'h0010);
      chk("rd_mem_we", mem_we, 0);
      chk("rd_ack_early", rd_ack, 0);
      tick();
      chk("rd_ack", rd_ack, 1);
      rd_req = 1'b0;
      tick();
      chk("rd_ack_pulse", rd_ack, 0);

      ext_reset = 1'b1;
      tick();
      chk("ext_reset_on", core_reset, 1);
      ext_reset = 1'b0;
      tick();
      chk("ext_reset_off", core_reset, 0);

      // Table-driven download, one strobe every 8 cycles.
      ioctl_download = 1'b1;
      tick();
      chk("load_core_reset", core_reset, 1);
      for (int i = 0; i < 6; i++) begin
         ioctl_addr = vecs[i].addr;
         ioctl_dout = vecs[i].dout;
         ioctl_wr = 1'b1;
         tick();
         ioctl_wr = 1'b0;
         chk($sformatf("v%0d_we_latency", i), mem_we, 0);
         tick();
         chk($sformatf("v%0d_we", i), mem_we, vecs[i].exp_we);
         if (vecs[i].exp_we) begin
            chk($sformatf("v%0d_addr", i), mem_addr, {16'h0, vecs[i].addr[15:0]});
            chk($sformatf("v%0d_din", i), mem_din, vecs[i].dout);
         end
         chk($sformatf("v%0d_bytes", i), dl_bytes, vecs[i].exp_bytes);
         chk($sformatf("v%0d_err", i), dl_err, vecs[i].exp_err);
         chk($sformatf("v%0d_core_reset", i), core_reset, 1);
         repeat (6) tick();
      end
      ioctl_download = 1'b0;
      count_reset_high(hi, we_seen);
      chk("dl_end_hold_len", hi, 258);
      chk("dl_end_extra_we", we_seen, 0);
      chk("dl_end_bytes", dl_bytes, 5);
      chk("dl_end_err", dl_err, 1);

      // Overflow: stall the write port so three back-to-back strobes meet a full FIFO.
      ioctl_download = 1'b1;
      tick();
      chk("ovf_clear_bytes", dl_bytes, 0);
      chk("ovf_clear_err", dl_err, 0);
      force dut.wr_grant = 1'b0;
      for (int k = 0; k < 3; k++) begin
         ioctl_addr = 25'h100 + 25'(k);
         ioctl_dout = 8'(k + 1);
         ioctl_wr = 1'b1;
         tick();
      end
      ioctl_wr = 1'b0;
      chk("ovf_err", dl_err, 1);
      chk("ovf_no_we_stalled", mem_we, 0);
      release dut.wr_grant;
      tick();
      chk("ovf_we0", mem_we, 1);
      chk("ovf_addr0", mem_addr, 16'h0100);
      chk("ovf_din0", mem_din, 8'h01);
      tick();
      chk("ovf_we1", mem_we, 1);
      chk("ovf_addr1", mem_addr, 16'h0101);
      chk("ovf_din1", mem_din, 8'h02);
      n = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (mem_we === 1'b1) n++;
      end
      chk("ovf_no_third_we", n, 0);
      chk("ovf_bytes", dl_bytes, 2);

      // Download ends with two entries pending; a read raised in FLUSH waits for the drain.
      force dut.wr_grant = 1'b0;
      ioctl_addr = 25'h20;
      ioctl_dout = 8'h11;
      ioctl_wr = 1'b1;
      tick();
      ioctl_addr = 25'h21;
      ioctl_dout = 8'h22;
      tick();
      ioctl_wr = 1'b0;
      ioctl_download = 1'b0;
      tick();
      tick();
      release dut.wr_grant;
      rd_addr = 16'h0040;
      rd_req = 1'b1;
      tick();
      chk("fl_we0", mem_we, 1);
      chk("fl_addr0", mem_addr, 16'h0020);
      chk("fl_din0", mem_din, 8'h11);
      chk("fl_no_ack0", rd_ack, 0);
      tick();
      chk("fl_we1", mem_we, 1);
      chk("fl_addr1", mem_addr, 16'h0021);
      chk("fl_din1", mem_din, 8'h22);
      tick();
      chk("fl_rd_we", mem_we, 0);
      chk("fl_rd_addr", mem_addr, 16'h0040);
      chk("fl_rd_ack_early", rd_ack, 0);
      tick();
      chk("fl_rd_ack", rd_ack, 1);
      rd_req = 1'b0;
      n = 2;
      while (core_reset === 1'b1 && n < 400) begin
         tick();
         n++;
      end
      chk("fl_hold_len", n, 256);
      chk("fl_bytes", dl_bytes, 4);
      chk("fl_err", dl_err, 1);

      // Reset in the middle of LOAD with an entry still queued.
      ioctl_download = 1'b1;
      tick();
      force dut.wr_grant = 1'b0;
      ioctl_addr = 25'h30;
      ioctl_dout = 8'h33;
      ioctl_wr = 1'b1;
      tick();
      ioctl_wr = 1'b0;
      ioctl_download = 1'b0;
      RESET_N = 1'b0;
      release dut.wr_grant;
      tick();
      chk("mrst_core_reset", core_reset, 1);
      chk("mrst_we", mem_we, 0);
      chk("mrst_bytes", dl_bytes, 0);
      tick();
      RESET_N = 1'b1;
      count_reset_high(hi, we_seen);
      chk("mrst_hold_len", hi, 256);
      chk("mrst_no_we", we_seen, 0);
      chk("mrst_bytes_after", dl_bytes, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
